// File: rtl/tilt_pkg.sv
// tilt_pkg: per-axis tilt state encoding and default thresholds shared by the
// tilt conditioner and its axis state machines.
package tilt_pkg;
  typedef enum logic [2:0] {CENTER, POS_PEND, POS, NEG_PEND, NEG} tilt_state_t;
  localparam int DEF_AVG_DEPTH = 4;
  localparam int DEF_DEAD_ZONE = 128;
  localparam int DEF_HYST = 32;
  localparam int DEF_HOLD_SAMPLES = 2;
endpackage

// File: rtl/tilt_axis_fsm.sv
// tilt_axis_fsm: dead-zone/hysteresis tilt classifier for one filtered axis;
// the state only moves when upd marks a fresh filtered sample.
module tilt_axis_fsm
  import tilt_pkg::*;
#(
  parameter int DEAD_ZONE = DEF_DEAD_ZONE,
  parameter int HYST = DEF_HYST,
  parameter int HOLD_SAMPLES = DEF_HOLD_SAMPLES
) (
  input  logic               slowclk,
  input  logic               reset_n,
  input  logic               upd,
  input  logic signed [15:0] filt,
  output logic               pos,
  output logic               neg
);
  localparam int CW = $clog2(HOLD_SAMPLES + 1);
  localparam logic signed [15:0] ENTER = 16'(DEAD_ZONE);
  localparam logic signed [15:0] LEAVE = 16'(DEAD_ZONE - HYST);
  localparam logic [CW-1:0] HOLD = CW'(HOLD_SAMPLES);
  tilt_state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
  logic above, below;
  always_comb begin
    above = filt > ENTER;
    below = filt < -ENTER;
    cnt_inc = cnt + 1'b1;
    state_nxt = state;
    cnt_nxt = cnt;
    if (upd)
      case (state)
        CENTER: begin
          state_nxt = above ? (HOLD_SAMPLES == 1 ? POS : POS_PEND)
                    : below ? (HOLD_SAMPLES == 1 ? NEG : NEG_PEND) : CENTER;
          cnt_nxt = (above || below) && HOLD_SAMPLES > 1 ? CW'(1) : '0;
        end
        POS_PEND: begin
          state_nxt = !above ? CENTER : cnt_inc == HOLD ? POS : POS_PEND;
          cnt_nxt = above && cnt_inc != HOLD ? cnt_inc : '0;
        end
        NEG_PEND: begin
          state_nxt = !below ? CENTER : cnt_inc == HOLD ? NEG : NEG_PEND;
          cnt_nxt = below && cnt_inc != HOLD ? cnt_inc : '0;
        end
        POS: state_nxt = filt < LEAVE ? CENTER : POS;
        NEG: state_nxt = filt > -LEAVE ? CENTER : NEG;
        default: state_nxt = CENTER;
      endcase
  end
  always_ff @(posedge slowclk or negedge reset_n)
    if (!reset_n) begin
      state <= CENTER;
      cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
    end
  assign pos = state == POS;
  assign neg = state == NEG;
endmodule

// File: rtl/tilt_conditioner.sv
// tilt_conditioner: accelerometer X/Y to left/right/up/down commands. Moving
// average filter enabled by TILT_CONDITIONER_AVG_EN, otherwise raw pass-through.
module tilt_conditioner
  import tilt_pkg::*;
#(
  parameter int AVG_DEPTH = DEF_AVG_DEPTH,
  parameter int DEAD_ZONE = DEF_DEAD_ZONE,
  parameter int HYST = DEF_HYST,
  parameter int HOLD_SAMPLES = DEF_HOLD_SAMPLES
) (
  input  logic               slowclk,
  input  logic               reset_n,
  input  logic               sample_valid,
  input  logic signed [15:0] data_x,
  input  logic signed [15:0] data_y,
  output logic signed [15:0] filt_x,
  output logic signed [15:0] filt_y,
  output logic               left,
  output logic               right,
  output logic               up,
  output logic               down,
  output logic               dir_valid
);
  if (AVG_DEPTH < 1 || AVG_DEPTH > 16 || (AVG_DEPTH & (AVG_DEPTH - 1)) != 0 || HOLD_SAMPLES < 1)
    $error("tilt_conditioner: bad AVG_DEPTH or HOLD_SAMPLES");
  logic raw_valid, filt_valid;
  logic signed [15:0] din [2];
  logic signed [15:0] filt [2];
  logic [1:0] pos, neg;
  assign din[0] = data_x;
  assign din[1] = data_y;
  always_ff @(posedge slowclk or negedge reset_n)
    if (!reset_n) begin
      raw_valid <= 1'b0;
      filt_valid <= 1'b0;
      dir_valid <= 1'b0;
    end else begin
      raw_valid <= sample_valid;
      filt_valid <= raw_valid;
      dir_valid <= filt_valid;
    end
  for (genvar a = 0; a < 2; a++) begin : ax
    logic signed [15:0] raw, f;
    always_ff @(posedge slowclk or negedge reset_n)
      if (!reset_n) raw <= '0;
      else if (sample_valid) raw <= din[a];
`ifdef TILT_CONDITIONER_AVG_EN
    localparam int L = $clog2(AVG_DEPTH);
    localparam int SW = 16 + L;
    logic signed [15:0] win [AVG_DEPTH];
    logic signed [SW-1:0] sum, sum_nxt;
    assign sum_nxt = sum + SW'(raw) - SW'(win[AVG_DEPTH-1]);
    // Arithmetic shift of the exact sum gives floor rounding for negatives.
    always_ff @(posedge slowclk or negedge reset_n)
      if (!reset_n) begin
        win <= '{default: '0};
        sum <= '0;
        f <= '0;
      end else if (raw_valid) begin
        win[0] <= raw;
        for (int i = 1; i < AVG_DEPTH; i++) win[i] <= win[i-1];
        sum <= sum_nxt;
        f <= 16'(sum_nxt >>> L);
      end
`else
    always_ff @(posedge slowclk or negedge reset_n)
      if (!reset_n) f <= '0;
      else if (raw_valid) f <= raw;
`endif
    assign filt[a] = f;
    tilt_axis_fsm #(
      .DEAD_ZONE(DEAD_ZONE),
      .HYST(HYST),
      .HOLD_SAMPLES(HOLD_SAMPLES)
    ) fsm (
      .slowclk(slowclk),
      .reset_n(reset_n),
      .upd(filt_valid),
      .filt(f),
      .pos(pos[a]),
      .neg(neg[a])
    );
  end
  assign filt_x = filt[0];
  assign filt_y = filt[1];
  assign left = pos[0];
  assign right = neg[0];
  assign down = pos[1];
  assign up = neg[1];
endmodule
